// File: rtl/inertial_pkg.sv
// Shared state encoding and SPI command words for the IMU read sequencer.
package inertial_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG1,
        CFG2,
        CFG3,
        CFG4,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        PUB
    } state_t;

    localparam logic [15:0] CMD_INT_EN  = 16'h0D02;
    localparam logic [15:0] CMD_ACC_ODR = 16'h1053;
    localparam logic [15:0] CMD_GYR_ODR = 16'h1150;
    localparam logic [15:0] CMD_ROUND   = 16'h1460;

    localparam logic [15:0] CMD_RD_PL = 16'hA200;
    localparam logic [15:0] CMD_RD_PH = 16'hA300;
    localparam logic [15:0] CMD_RD_AL = 16'hAC00;
    localparam logic [15:0] CMD_RD_AH = 16'hAD00;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/inertial_read_sequencer.sv
// IMU power-up wait, configuration writes, and interrupt-driven pitch-rate/AZ sample reads.
module inertial_read_sequencer
    import inertial_pkg::*;
#(
    parameter int INIT_WAIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    // state     | meaning
    // INIT_WAIT | counting out IMU power-up
    // CFG1..4   | config write outstanding (0D02, 1053, 1150, 1460)
    // IDLE      | waiting for synchronized data-ready
    // RD_PL..AH | read outstanding for pitch low/high, AZ low/high
    // PUB       | vld cycle; behaves as IDLE so a held INT retriggers at once

    localparam logic [INIT_WAIT_W-1:0] CNT_LAUNCH = {INIT_WAIT_W{1'b1}} - 1'b1;

    state_t                 r_state;
    logic [INIT_WAIT_W-1:0] r_cnt;
    logic                   r_wrt;
    logic [15:0]            r_cmd;
    logic [15:0]            r_ptch;
    logic [15:0]            r_az;
    logic                   r_vld;
    logic [7:0]             r_pl;
    logic [7:0]             r_ph;
    logic [7:0]             r_al;

    logic                   w_int_s;
    logic                   w_done_ok;
    logic [7:0]             w_byte;
    logic                   w_rd_hi_unused;

    sync2 u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (INT),
        .o_q   (w_int_s)
    );

    // A done coinciding with our own wrt cannot belong to the new transaction.
    assign w_done_ok      = done & ~r_wrt;
    assign w_byte         = rd_data[7:0];
    assign w_rd_hi_unused = ^rd_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT_WAIT;
            r_cnt   <= '0;
            r_wrt   <= 1'b0;
            r_cmd   <= 16'h0000;
            r_ptch  <= 16'h0000;
            r_az    <= 16'h0000;
            r_vld   <= 1'b0;
            r_pl    <= 8'h00;
            r_ph    <= 8'h00;
            r_al    <= 8'h00;
        end else begin
            r_wrt <= 1'b0;
            r_vld <= 1'b0;
            case (r_state)
                INIT_WAIT: begin
                    // Launch lands in the cycle the counter reads all-ones, where it then parks.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAUNCH) begin
                        r_wrt   <= 1'b1;
                        r_cmd   <= CMD_INT_EN;
                        r_state <= CFG1;
                    end
                end
                CFG1: if (w_done_ok) begin
                    r_wrt   <= 1'b1;
                    r_cmd   <= CMD_ACC_ODR;
                    r_state <= CFG2;
                end
                CFG2: if (w_done_ok) begin
                    r_wrt   <= 1'b1;
                    r_cmd   <= CMD_GYR_ODR;
                    r_state <= CFG3;
                end
                CFG3: if (w_done_ok) begin
                    r_wrt   <= 1'b1;
                    r_cmd   <= CMD_ROUND;
                    r_state <= CFG4;
                end
                CFG4: if (w_done_ok) begin
                    r_state <= IDLE;
                end
                IDLE, PUB: begin
                    if (w_int_s) begin
                        r_wrt   <= 1'b1;
                        r_cmd   <= CMD_RD_PL;
                        r_state <= RD_PL;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_PL: if (w_done_ok) begin
                    r_pl    <= w_byte;
                    r_wrt   <= 1'b1;
                    r_cmd   <= CMD_RD_PH;
                    r_state <= RD_PH;
                end
                RD_PH: if (w_done_ok) begin
                    r_ph    <= w_byte;
                    r_wrt   <= 1'b1;
                    r_cmd   <= CMD_RD_AL;
                    r_state <= RD_AL;
                end
                RD_AL: if (w_done_ok) begin
                    r_al    <= w_byte;
                    r_wrt   <= 1'b1;
                    r_cmd   <= CMD_RD_AH;
                    r_state <= RD_AH;
                end
                RD_AH: if (w_done_ok) begin
                    r_ptch  <= {r_ph, r_pl};
                    r_az    <= {w_byte, r_al};
                    r_vld   <= 1'b1;
                    r_state <= PUB;
                end
                default: r_state <= INIT_WAIT;
            endcase
        end
    end

    assign wrt     = r_wrt;
    assign cmd     = r_cmd;
    assign ptch_rt = r_ptch;
    assign AZ      = r_az;
    assign vld     = r_vld;

endmodule

// File: tb/tb_inertial_read_sequencer.sv
// Directed bench for inertial_read_sequencer with a fixed-latency SPI responder.
module tb_inertial_read_sequencer;

    localparam int W        = 12;
    localparam int WAIT_CYC = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    always #5 clk = ~clk;

    inertial_read_sequencer #(.INIT_WAIT_W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] cmd_q[$];
    int          wrt_cyc[$];
    int          done_cyc[$];
    logic [15:0] pr_q[$];
    logic [15:0] az_q[$];
    int          vld_cyc[$];
    logic [7:0]  rd_q[$];

    always @(negedge clk) begin
        if (wrt) begin
            cmd_q.push_back(cmd);
            wrt_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (vld) begin
            pr_q.push_back(ptch_rt);
            az_q.push_back(AZ);
            vld_cyc.push_back(cyc);
        end
    end

    // SPI responder: done ten cycles after each wrt; read commands return the next queued byte.
    logic [15:0] m_cmd;
    initial begin
        done    = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            while (wrt === 1'b1) begin
                m_cmd = cmd;
                repeat (10) @(posedge clk);
                #1;
                done = 1'b1;
                if (m_cmd[15] && rd_q.size() > 0) rd_data = {8'h00, rd_q.pop_front()};
                else rd_data = 16'h0000;
                @(posedge clk);
                #1;
                done    = 1'b0;
                rd_data = 16'h0000;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wrt(input int target, input int budget, input string tag);
        int k = 0;
        while (cmd_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, cmd_q.size(), target);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_cyc.size() < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, done_cyc.size(), target);
    endtask

    task automatic wait_vld(input int target, input int budget, input string tag);
        int k = 0;
        while (vld_cyc.size() < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, vld_cyc.size(), target);
    endtask

    logic [15:0] exp_cmd [8] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460,
                                 16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    int rel;
    int nw;
    int nv;

    initial begin
        rst_n = 1'b0;
        INT   = 1'b0;
        repeat (3) tick();
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_ptch", ptch_rt, 16'h0000);
        check("rst_az", AZ, 16'h0000);
        check("rst_vld", vld, 0);

        // Boot: INT pulses during INIT_WAIT and CFG2 must not provoke reads.
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        repeat (50) tick();
        INT = 1'b1;
        repeat (3) tick();
        INT = 1'b0;
        wait_wrt(1, WAIT_CYC + 20, "first_wrt_seen");
        if (cmd_q.size() >= 1) begin
            check("init_wait_cycles", wrt_cyc[0] - rel, WAIT_CYC);
            check("first_cmd", cmd_q[0], 16'h0D02);
        end
        wait_wrt(2, 40, "cfg2_entered");
        INT = 1'b1;
        repeat (3) tick();
        INT = 1'b0;
        wait_done(4, 100, "cfg_done_count");
        repeat (30) tick();
        check("cfg_wrt_count", cmd_q.size(), 4);
        for (int i = 0; i < 4 && i < cmd_q.size(); i++) check($sformatf("cfg_cmd%0d", i), cmd_q[i], exp_cmd[i]);
        for (int i = 1; i < 4 && i < wrt_cyc.size(); i++)
            check($sformatf("cfg_wrt_after_done%0d", i), wrt_cyc[i] - done_cyc[i-1], 1);

        // Single sample.
        rd_q = '{8'h34, 8'h12, 8'h60, 8'hFF};
        INT  = 1'b1;
        wait_wrt(5, 20, "rd_start");
        INT = 1'b0;
        wait_vld(1, 200, "vld1_seen");
        repeat (5) tick();
        for (int i = 4; i < 8 && i < cmd_q.size(); i++) check($sformatf("rd_cmd%0d", i - 4), cmd_q[i], exp_cmd[i]);
        check("vld_count_1", vld_cyc.size(), 1);
        check("ptch_rt_1", ptch_rt, 16'h1234);
        check("az_1", AZ, 16'hFF60);
        if (vld_cyc.size() >= 1 && done_cyc.size() >= 8)
            check("vld_after_done", vld_cyc[0] - done_cyc[7], 1);

        // INT held: back-to-back chains; a third chain starts before INT_s falls.
        rd_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        INT  = 1'b1;
        wait_vld(3, 400, "held_vld3_seen");
        INT = 1'b0;
        wait_vld(4, 200, "held_vld4_seen");
        repeat (20) tick();
        check("held_vld_count", vld_cyc.size(), 4);
        if (pr_q.size() >= 4) begin
            check("held_ptch_a", pr_q[1], 16'h0001);
            check("held_az_a", az_q[1], 16'h0002);
            check("held_ptch_b", pr_q[2], 16'h0003);
            check("held_az_b", az_q[2], 16'h0004);
            check("held_ptch_c", pr_q[3], 16'h0000);
        end
        if (wrt_cyc.size() >= 13 && vld_cyc.size() >= 2) begin
            check("retrigger_gap", wrt_cyc[12] - vld_cyc[1], 1);
            check("retrigger_cmd", cmd_q[12], 16'hA200);
        end

        // Reset one cycle after the AZ-low done.
        rd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        INT  = 1'b1;
        wait_wrt(21, 20, "rst_chain_start");
        INT = 1'b0;
        wait_done(23, 200, "rst_chain_al_done");
        tick();
        nv    = vld_cyc.size();
        rst_n = 1'b0;
        #1;
        check("midrst_wrt", wrt, 0);
        check("midrst_cmd", cmd, 16'h0000);
        check("midrst_ptch", ptch_rt, 16'h0000);
        check("midrst_az", AZ, 16'h0000);
        check("midrst_vld", vld, 0);
        repeat (20) tick();
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        nw    = cmd_q.size();
        wait_wrt(nw + 1, WAIT_CYC + 20, "reboot_wrt_seen");
        if (cmd_q.size() > nw) begin
            check("reboot_wait_cycles", wrt_cyc[nw] - rel, WAIT_CYC);
            check("reboot_cmd", cmd_q[nw], 16'h0D02);
        end
        check("midrst_no_vld", vld_cyc.size(), nv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
